gdiv_ctrl: RTL

Sequencing controller for the Goldschmidt divider datapath (`main`). It accepts a start request and walks the datapath through its fixed control schedule: initial scaling, first reciprocal step, and `ITERS` refinement pairs. It then presents the result with a one-cycle `done` pulse. It replaces hand-driven mux selects and load enables, and sits between the issue logic and the datapath.

---
 rtl/gdiv_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gdiv_ctrl.sv
// Sequencing controller for the Goldschmidt divider datapath: drives mux selects
// and load enables through init, first step and ITERS refinement pairs.
module gdiv_ctrl #(
    parameter int ITERS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       Sn,
    input  logic       Sd,
    output logic [2:0] Ma,
    output logic [1:0] Mb,
    output logic       Ms,
    output logic       Mq,
    output logic       La,
    output logic       Lb,
    output logic       Lk,
    output logic       busy,
    output logic       done,
    output logic       q_sign
);

    // state   | meaning
    // IDLE    | waiting for start, all outputs 0
    // INIT_A  | initial scaling, load A
    // INIT_B  | initial scaling, load B and K
    // FIRST_A | first reciprocal step, load A
    // FIRST_B | first reciprocal step, load B and K
    // ITER    | refinement steps j = 0..2*ITERS-1
    // DONE    | result valid, done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_INIT_A, S_INIT_B, S_FIRST_A, S_FIRST_B, S_ITER, S_DONE
    } state_t;

    localparam int STEPS = 2 * ITERS;
    localparam int JW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(STEPS - 1);

    state_t          state_q, state_d;
    logic [JW-1:0]   j_q, j_d;
    logic [1:0]      ph_q, ph_d;
    logic            q_sign_q, q_sign_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            j_q      <= '0;
            ph_q     <= '0;
            q_sign_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            ph_q     <= ph_d;
            q_sign_q <= q_sign_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        ph_d     = ph_q;
        q_sign_d = q_sign_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_INIT_A;
                    q_sign_d = Sn ^ Sd;
                end
            end
            S_INIT_A:  state_d = S_INIT_B;
            S_INIT_B:  state_d = S_FIRST_A;
            S_FIRST_A: state_d = S_FIRST_B;
            S_FIRST_B: begin
                state_d = S_ITER;
                j_d     = '0;
                ph_d    = '0;
            end
            S_ITER: begin
                j_d  = j_q + JW'(1);
                // mod-3 phase kept as its own wrapping counter
                ph_d = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
                if (j_q == J_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_d  = S_INIT_A;
                    q_sign_d = Sn ^ Sd;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Ma   = 3'd0;
        Mb   = 2'd0;
        Ms   = 1'b0;
        Mq   = 1'b0;
        La   = 1'b0;
        Lb   = 1'b0;
        Lk   = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_INIT_A: begin
                Mb = 2'd1; Ma = 3'd5; Mq = 1'b1; La = 1'b1; busy = 1'b1;
            end
            S_INIT_B: begin
                Mb = 2'd1; Ma = 3'd4; Mq = 1'b1; Lb = 1'b1; Lk = 1'b1; busy = 1'b1;
            end
            S_FIRST_A: begin
                Mb = 2'd2; Ma = 3'd1; Mq = 1'b1; La = 1'b1; busy = 1'b1;
            end
            S_FIRST_B: begin
                Mb = 2'd2; Ma = 3'd4; Mq = 1'b1; Lb = 1'b1; Lk = 1'b1; busy = 1'b1;
            end
            S_ITER: begin
                Mb   = 2'd2;
                Mq   = 1'b1;
                Ma   = 3'd2 + {1'b0, ph_q};
                La   = ~j_q[0];
                Lb   = j_q[0];
                Lk   = j_q[0];
                busy = 1'b1;
            end
            S_DONE: begin
                Mb = 2'd2; Ma = 3'd2; Mq = 1'b1; done = 1'b1;
            end
            default: ;
        endcase
    end

    assign q_sign = q_sign_q;

endmodule
